// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Module : btn_pkg
// Brief  : Shared event encoding and sizing helper for the button scanner.
// Rev    : 1.0
// ============================================================================
package btn_pkg;

  localparam logic EVT_PRESS   = 1'b1;
  localparam logic EVT_RELEASE = 1'b0;
  localparam int   IDX_MAX_W   = 3;

  typedef struct packed {
    logic                 dir;
    logic [IDX_MAX_W-1:0] idx;
  } evt_t;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_evt_fifo.sv
`default_nettype none
// ============================================================================
// Module : btn_evt_fifo
// Brief  : Small synchronous FIFO with full/empty flags for button events.
// Rev    : 1.0
// ============================================================================
module btn_evt_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic             w_do_push;
  logic             w_do_pop;

  assign full_o    = (r_cnt == (AW+1)'(DEPTH));
  assign empty_o   = (r_cnt == '0);
  assign w_do_push = push_i & ~full_o;
  assign w_do_pop  = pop_i & ~empty_o;
  // Head is forced to zero when empty so the code output reads 0 out of reset.
  assign data_o    = empty_o ? '0 : r_mem[r_rd];

  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/btn_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : btn_scan_ctrl
// Brief  : Debounces active-low buttons and queues press/release events.
// Rev    : 1.0
// ============================================================================
module btn_scan_ctrl
  import btn_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [N_BTN-1:0]      btn_n_i,
  input  logic                  en_i,
  output logic [N_BTN-1:0]      state_o,
  output logic                  evt_valid_o,
  input  logic                  evt_ready_i,
  output logic [idx_w(N_BTN):0] evt_code_o,
  output logic                  ovf_o,
  input  logic                  ovf_clr_i
);

  localparam int IW = idx_w(N_BTN);
  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(STABLE_TICKS);

  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;
  logic [PW-1:0]    r_pre;
  logic [CW-1:0]    r_cnt [N_BTN];
  logic [N_BTN-1:0] r_state;
  logic [N_BTN-1:0] r_pend;
  logic [N_BTN-1:0] r_pend_dir;
  logic [IW-1:0]    r_rr;
  logic             r_ovf;

  logic             w_tick;
  logic [N_BTN-1:0] w_toggle;
  logic [N_BTN-1:0] w_grant;
  logic [IW-1:0]    w_gidx;
  logic [IW-1:0]    w_rr_nxt;
  logic             w_found;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  logic [IW:0]      w_push_data;

  assign state_o     = r_state;
  assign ovf_o       = r_ovf;
  assign evt_valid_o = ~w_empty;
  assign w_tick      = en_i && (r_pre == PW'(TICK_DIV - 1));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_pre   <= '0;
    end else begin
      r_sync1 <= ~btn_n_i;
      r_sync2 <= r_sync1;
      if (!en_i || w_tick) r_pre <= '0;
      else                 r_pre <= r_pre + 1'b1;
    end
  end

  always_comb begin
    w_toggle = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_toggle[i] = w_tick && (r_sync2[i] != r_state[i]) &&
                    (r_cnt[i] == CW'(STABLE_TICKS - 1));
    end
  end

  // Round-robin search over pending bits, starting at the rotating pointer.
  always_comb begin : p_arb
    int k;
    k       = 0;
    w_found = 1'b0;
    w_gidx  = '0;
    for (int j = 0; j < N_BTN; j++) begin
      k = (int'(r_rr) + j) % N_BTN;
      if (!w_found && r_pend[k]) begin
        w_found = 1'b1;
        w_gidx  = IW'(k);
      end
    end
    w_push      = w_found && !w_full;
    w_grant     = w_push ? (N_BTN'(1) << w_gidx) : '0;
    w_rr_nxt    = (w_gidx == IW'(N_BTN - 1)) ? '0 : w_gidx + 1'b1;
    w_push_data = {(r_pend_dir[w_gidx] ? EVT_PRESS : EVT_RELEASE), w_gidx};
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < N_BTN; i++) r_cnt[i] <= '0;
      r_state    <= '0;
      r_pend     <= '0;
      r_pend_dir <= '0;
      r_rr       <= '0;
      r_ovf      <= 1'b0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (!en_i || (r_sync2[i] == r_state[i])) r_cnt[i] <= '0;
        else if (w_tick) r_cnt[i] <= w_toggle[i] ? '0 : r_cnt[i] + 1'b1;
        // A fresh toggle wins over the grant of the older event it replaces.
        if (w_toggle[i]) begin
          r_state[i]    <= ~r_state[i];
          r_pend[i]     <= 1'b1;
          r_pend_dir[i] <= ~r_state[i];
        end else if (w_grant[i]) begin
          r_pend[i]     <= 1'b0;
        end
      end
      if (w_push) r_rr <= w_rr_nxt;
      if (|(w_toggle & r_pend & ~w_grant)) r_ovf <= 1'b1;
      else if (ovf_clr_i)                  r_ovf <= 1'b0;
    end
  end

  btn_evt_fifo #(
    .WIDTH (IW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (w_push),
    .data_i  (w_push_data),
    .pop_i   (evt_ready_i),
    .data_o  (evt_code_o),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_btn_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_btn_scan_ctrl
// Brief  : Directed scoreboard bench for btn_scan_ctrl (4 buttons, fast tick).
// Rev    : 1.0
// ============================================================================
module tb_btn_scan_ctrl;

  logic       clk_i;
  logic       rstn_i;
  logic [3:0] btn_n_i;
  logic       en_i;
  logic [3:0] state_o;
  logic       evt_valid_o;
  logic       evt_ready_i;
  logic [2:0] evt_code_o;
  logic       ovf_o;
  logic       ovf_clr_i;

  int         checks;
  int         errors;
  logic [2:0] exp_q [$];

  btn_scan_ctrl #(
    .N_BTN        (4),
    .TICK_DIV     (4),
    .STABLE_TICKS (3),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .btn_n_i     (btn_n_i),
    .en_i        (en_i),
    .state_o     (state_o),
    .evt_valid_o (evt_valid_o),
    .evt_ready_i (evt_ready_i),
    .evt_code_o  (evt_code_o),
    .ovf_o       (ovf_o),
    .ovf_clr_i   (ovf_clr_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic btn_set(input logic [3:0] v, input int hold);
    btn_n_i = v;
    cyc(hold);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    checks      = 0;
    errors      = 0;
    rstn_i      = 1'b1;
    btn_n_i     = 4'hF;
    en_i        = 1'b1;
    evt_ready_i = 1'b1;
    ovf_clr_i   = 1'b0;

    fork
      forever begin
        @(negedge clk_i);
        if (rstn_i && evt_valid_o && evt_ready_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL evt_unexpected got %b required no event", evt_code_o);
          end else begin
            chk("evt_code", {29'b0, evt_code_o}, {29'b0, exp_q.pop_front()});
          end
        end
      end
    join_none

    #2 rstn_i = 1'b0;
    cyc(3);
    chk("rst_state", {28'b0, state_o}, 32'h0);
    chk("rst_valid", {31'b0, evt_valid_o}, 32'h0);
    chk("rst_code",  {29'b0, evt_code_o}, 32'h0);
    chk("rst_ovf",   {31'b0, ovf_o}, 32'h0);
    rstn_i = 1'b1;
    cyc(2);

    // Simultaneous press on buttons 0 and 3 with the pointer at 0.
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b111);
    btn_set(4'b0110, 20);
    chk("dual_press_state", {28'b0, state_o}, 32'h9);
    exp_q.push_back(3'b000);
    exp_q.push_back(3'b011);
    btn_set(4'hF, 20);
    chk("dual_release_state", {28'b0, state_o}, 32'h0);

    exp_q.push_back(3'b110);
    btn_set(4'b1011, 20);
    chk("btn2_press_state", {28'b0, state_o}, 32'h4);
    exp_q.push_back(3'b010);
    btn_set(4'hF, 20);
    chk("btn2_release_state", {28'b0, state_o}, 32'h0);

    // Five-cycle glitch spans at most two ticks: no acceptance.
    btn_set(4'b1101, 5);
    btn_set(4'hF, 20);
    chk("glitch_state", {28'b0, state_o}, 32'h0);

    // Fill the queue, hold two pending events, then overwrite one.
    evt_ready_i = 1'b0;
    exp_q.push_back(3'b101); btn_set(4'b1101, 20);
    exp_q.push_back(3'b001); btn_set(4'hF, 20);
    exp_q.push_back(3'b101); btn_set(4'b1101, 20);
    exp_q.push_back(3'b001); btn_set(4'hF, 20);
    chk("full_valid", {31'b0, evt_valid_o}, 32'h1);
    exp_q.push_back(3'b100); btn_set(4'b1110, 20);
    btn_set(4'b1100, 20);
    chk("pend_no_ovf", {31'b0, ovf_o}, 32'h0);
    exp_q.push_back(3'b001); btn_set(4'b1110, 20);
    chk("ovf_set", {31'b0, ovf_o}, 32'h1);
    chk("ovf_state", {28'b0, state_o}, 32'h1);
    ovf_clr_i = 1'b1;
    cyc(1);
    ovf_clr_i = 1'b0;
    chk("ovf_clr", {31'b0, ovf_o}, 32'h0);
    evt_ready_i = 1'b1;
    cyc(20);
    chk("drained_valid", {31'b0, evt_valid_o}, 32'h0);
    exp_q.push_back(3'b000);
    btn_set(4'hF, 20);

    // Async reset with two queued events and a count in progress.
    evt_ready_i = 1'b0;
    btn_set(4'b0011, 20);
    btn_set(4'b0010, 6);
    @(posedge clk_i);
    #2 rstn_i = 1'b0;
    #1;
    chk("arst_state", {28'b0, state_o}, 32'h0);
    chk("arst_valid", {31'b0, evt_valid_o}, 32'h0);
    chk("arst_code",  {29'b0, evt_code_o}, 32'h0);
    chk("arst_ovf",   {31'b0, ovf_o}, 32'h0);
    btn_n_i = 4'hF;
    cyc(3);
    rstn_i      = 1'b1;
    evt_ready_i = 1'b1;
    cyc(30);
    chk("post_rst_valid", {31'b0, evt_valid_o}, 32'h0);
    chk("post_rst_state", {28'b0, state_o}, 32'h0);

    // Scan disabled: no acceptance while held; acceptance after re-enable.
    en_i = 1'b0;
    btn_set(4'b1011, 30);
    chk("dis_state", {28'b0, state_o}, 32'h0);
    exp_q.push_back(3'b110);
    en_i = 1'b1;
    cyc(16);
    chk("en_state", {28'b0, state_o}, 32'h4);
    exp_q.push_back(3'b010);
    btn_set(4'hF, 20);
    cyc(5);
    chk("scoreboard_drained", exp_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
